core_run_ctrl: RTL

//  Boot and run-control unit for N_CORES processor cores sharing one host-side program loader.
//  - Streams program words into each selected core's program memory (PM).
//  - Holds the cores in reset while loading, then releases them after a fixed delay.
//  - Gates each core with a clock-enable, supporting halt, single-step and resume.
//  - Counts run cycles. Sits between the host/test interface and the core tops.

---
 rtl/core_ctrl_pkg.sv | 37 +++
 rtl/pm_load_seq.sv | 64 ++++++
 rtl/core_run_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core boot/run controller: FSM state encodings
// and the fixed priority order used to arbitrate simultaneous commands.
package core_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_HALT    = 3'd4,
    ST_STEP    = 3'd5
  } run_state_e;

  // Winning command after arbitration, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LOAD   = 3'd1,
    CMD_HALT   = 3'd2,
    CMD_STEP   = 3'd3,
    CMD_RESUME = 3'd4
  } cmd_e;

  // Load beats everything; among the rest halt > step > resume.
  function automatic cmd_e pick_cmd(input logic load, input logic halt,
                                    input logic step, input logic resume);
    cmd_e c;
    c = CMD_NONE;
    if (load)        c = CMD_LOAD;
    else if (halt)   c = CMD_HALT;
    else if (step)   c = CMD_STEP;
    else if (resume) c = CMD_RESUME;
    return c;
  endfunction

endpackage

// File: rtl/pm_load_seq.sv
// Program-memory load sequencer: tracks the next PM address, drops words that
// would land above the top of PM (no wrap), and registers the write strobe,
// address and data one cycle after each accepted word.
module pm_load_seq
  import core_ctrl_pkg::*;
#(
  parameter int N_CORES  = 2,
  parameter int PMA_SIZE = 16,
  parameter int PMD_SIZE = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PMA_SIZE-1:0] base,
  input  logic [N_CORES-1:0]  core_sel,
  input  logic                accept,
  input  logic [PMD_SIZE-1:0] data,
  output logic [N_CORES-1:0]  pm_wr_en,
  output logic [PMA_SIZE-1:0] pm_wr_add,
  output logic [PMD_SIZE-1:0] pm_wr_dt,
  output logic [PMA_SIZE:0]   words_loaded,
  output logic                err_ovf
);

  // One extra address bit: once it is set the load has run off the top of PM
  // and the counter stops, so the address can never wrap back into range.
  logic [PMA_SIZE:0]  addr_q;
  logic [N_CORES-1:0] sel_q;
  logic               past_top;

  assign past_top = addr_q[PMA_SIZE];

  // Address/index counter, overflow flag and registered write stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      sel_q        <= '0;
      pm_wr_en     <= '0;
      pm_wr_add    <= '0;
      pm_wr_dt     <= '0;
      words_loaded <= '0;
      err_ovf      <= 1'b0;
    end else begin
      pm_wr_en <= '0;
      if (start) begin
        addr_q       <= {1'b0, base};
        sel_q        <= core_sel;
        words_loaded <= '0;
        err_ovf      <= 1'b0;
      end else if (accept) begin
        if (past_top) begin
          err_ovf <= 1'b1;
        end else begin
          pm_wr_en     <= sel_q;
          pm_wr_add    <= addr_q[PMA_SIZE-1:0];
          pm_wr_dt     <= data;
          addr_q       <= addr_q + (PMA_SIZE+1)'(1);
          words_loaded <= words_loaded + (PMA_SIZE+1)'(1);
        end
      end
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Boot and run-control unit: loads program memory for selected cores, holds
// them in reset, releases them after a fixed delay, and gates their clock
// enables for run / halt / single-step while counting run cycles.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  IDLE     | cores held in reset, waiting for load or resume
//  LOAD     | streaming program words into PM, cores in reset
//  RELEASE  | reset held for RST_CYCLES cycles before running
//  RUN      | cores in run_mask_q enabled, run_cnt counting
//  HALT     | clock enables off, cores out of reset
//  STEP     | one enabled cycle, then back to HALT
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int N_CORES    = 2,
  parameter int PMA_SIZE   = 16,
  parameter int PMD_SIZE   = 32,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_load,
  input  logic [PMA_SIZE-1:0] ld_base,
  input  logic [N_CORES-1:0]  ld_core_sel,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [PMD_SIZE-1:0] ld_data,
  input  logic                ld_last,
  output logic [N_CORES-1:0]  pm_wr_en,
  output logic [PMA_SIZE-1:0] pm_wr_add,
  output logic [PMD_SIZE-1:0] pm_wr_dt,
  input  logic                cmd_halt,
  input  logic                cmd_step,
  input  logic                cmd_resume,
  input  logic [N_CORES-1:0]  run_mask,
  output logic [N_CORES-1:0]  core_rst,
  output logic [N_CORES-1:0]  core_en,
  output logic [STATE_W-1:0]  state_o,
  output logic [CNT_W-1:0]    run_cnt,
  output logic [PMA_SIZE:0]   words_loaded,
  output logic                err_ovf
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] REL_LOAD = RC_W'(RST_CYCLES - 1);

  run_state_e         state_q, state_d;
  cmd_e               cmd;
  logic [N_CORES-1:0] run_mask_q;
  logic [RC_W-1:0]    rel_cnt_q;
  logic               accept;
  logic               load_start;

  assign cmd        = pick_cmd(cmd_load, cmd_halt, cmd_step, cmd_resume);
  assign load_start = (cmd == CMD_LOAD);
  assign accept     = ld_valid && (state_q == ST_LOAD);
  assign state_o    = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and per-state outputs; a load command overrides all.
  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    core_rst = '1;
    core_en  = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd == CMD_RESUME) state_d = ST_RELEASE;
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (rel_cnt_q == '0) state_d = ST_RUN;
      end
      ST_RUN: begin
        core_rst = ~run_mask_q;
        core_en  = run_mask_q;
        if (cmd == CMD_HALT) state_d = ST_HALT;
      end
      ST_HALT: begin
        core_rst = ~run_mask_q;
        if (cmd == CMD_STEP)        state_d = ST_STEP;
        else if (cmd == CMD_RESUME) state_d = ST_RUN;
      end
      ST_STEP: begin
        core_rst = ~run_mask_q;
        core_en  = run_mask_q;
        state_d  = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_start) state_d = ST_LOAD;
  end

  // Release delay down-counter, loaded on entry to RELEASE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rel_cnt_q <= '0;
    end else if (state_d == ST_RELEASE && state_q != ST_RELEASE) begin
      rel_cnt_q <= REL_LOAD;
    end else if (state_q == ST_RELEASE && rel_cnt_q != '0) begin
      rel_cnt_q <= rel_cnt_q - RC_W'(1);
    end
  end

  // Capture the run mask each time the FSM enters RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_mask_q <= '0;
    end else if (state_d == ST_RUN && state_q != ST_RUN) begin
      run_mask_q <= run_mask;
    end
  end

  // Saturating count of enabled cycles (RUN and STEP).
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
    end else if ((state_q == ST_RUN || state_q == ST_STEP) && run_cnt != '1) begin
      run_cnt <= run_cnt + CNT_W'(1);
    end
  end

  pm_load_seq #(
    .N_CORES  (N_CORES),
    .PMA_SIZE (PMA_SIZE),
    .PMD_SIZE (PMD_SIZE)
  ) u_pm_load_seq (
    .clk          (clk),
    .reset        (reset),
    .start        (load_start),
    .base         (ld_base),
    .core_sel     (ld_core_sel),
    .accept       (accept),
    .data         (ld_data),
    .pm_wr_en     (pm_wr_en),
    .pm_wr_add    (pm_wr_add),
    .pm_wr_dt     (pm_wr_dt),
    .words_loaded (words_loaded),
    .err_ovf      (err_ovf)
  );

endmodule
